// File: rtl/rca_pkg.sv
// Shared constants and types for the ripple-carry adder slice.
// Optional feature macro used by this slice: RCA_OVF_EN (adds the registered ovf output).
package rca_pkg;

  // Default operand/sum width of the adder.
  localparam int unsigned RCA_DEFAULT_WIDTH = 64;

  // Operand vector at the default width.
  typedef logic [RCA_DEFAULT_WIDTH-1:0] rca_operand_t;

  // Signed overflow from the carries into and out of the MSB.
  function automatic logic rca_signed_ovf(input logic carry_into_msb, input logic carry_out_msb);
    return carry_into_msb ^ carry_out_msb;
  endfunction

endpackage

// File: rtl/full_adder.sv
// One-bit full adder cell; the unit replicated along the ripple-carry chain.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  logic w_p;

  // Sum and carry from generate/propagate terms.
  always_comb begin
    w_p = a ^ b;
    s   = w_p ^ ci;
    co  = (a & b) | (ci & w_p);
  end

endmodule

// File: rtl/rca_64bit.sv
// Registered ripple-carry adder: WIDTH explicit full-adder cells feeding one output register
// stage. Result of a/b/cin sampled at an edge appears on sum/cout right after that edge.
// Optional feature macro: RCA_OVF_EN adds a registered two's-complement overflow output ovf.
module rca_64bit
  import rca_pkg::*;
#(
  parameter int unsigned WIDTH = RCA_DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
`ifdef RCA_OVF_EN
  output logic             cout,
  output logic             ovf
`else
  output logic             cout
`endif
);

  logic [WIDTH-1:0] w_sum;
  logic             w_cout;
  logic             w_carry_msb;  // carry into bit WIDTH-1

  logic [WIDTH-1:0] r_sum;
  logic             r_cout;

  // Each stage keeps its own carry nets and links to the previous stage by name, so the chain
  // is a plain sequence of scalar nets rather than one self-referencing vector.
  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    logic w_ci;
    logic w_co;

    if (i == 0) begin : g_first
      assign w_ci = cin;
    end else begin : g_link
      assign w_ci = g_bit[i-1].w_co;
    end

    full_adder u_fa (
      .a  (a[i]),
      .b  (b[i]),
      .ci (w_ci),
      .s  (w_sum[i]),
      .co (w_co)
    );
  end

  assign w_cout      = g_bit[WIDTH-1].w_co;
  assign w_carry_msb = g_bit[WIDTH-1].w_ci;

  // Output register stage; reset clears the result regardless of operands.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sum  <= '0;
      r_cout <= 1'b0;
    end else begin
      r_sum  <= w_sum;
      r_cout <= w_cout;
    end
  end

  assign sum  = r_sum;
  assign cout = r_cout;

`ifdef RCA_OVF_EN
  logic r_ovf;

  // Registered signed overflow, cleared alongside the sum.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ovf <= 1'b0;
    end else begin
      r_ovf <= rca_signed_ovf(w_carry_msb, w_cout);
    end
  end

  assign ovf = r_ovf;
`else
  logic w_unused;
  assign w_unused = w_carry_msb;
`endif

endmodule

// File: tb/tb_rca_64bit.sv
// Directed and randomized checks of the registered ripple-carry adder.
module tb_rca_64bit;
  import rca_pkg::*;

  localparam int unsigned W = RCA_DEFAULT_WIDTH;

  logic         clk;
  logic         rst;
  rca_operand_t a;
  rca_operand_t b;
  logic         cin;
  rca_operand_t sum;
  logic         cout;
`ifdef RCA_OVF_EN
  logic         ovf;
`endif

  int n_total;
  int n_bad;

  rca_64bit #(
    .WIDTH (W)
  ) dut (
    .clk  (clk),
    .rst  (rst),
    .a    (a),
    .b    (b),
    .cin  (cin),
    .sum  (sum),
`ifdef RCA_OVF_EN
    .cout (cout),
    .ovf  (ovf)
`else
    .cout (cout)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance past the next rising edge and settle before sampling.
  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      a   = {$urandom(), $urandom()};
      b   = {$urandom(), $urandom()};
      cin = 1'b1;
      cycle();
      n_total++;
      if (sum !== '0 || cout !== 1'b0) begin
        $display("FAIL reset[%0d]: got sum=%0h cout=%b want sum=0 cout=0", i, sum, cout);
        n_bad++;
      end
`ifdef RCA_OVF_EN
      n_total++;
      if (ovf !== 1'b0) begin
        $display("FAIL reset_ovf[%0d]: got %b want 0", i, ovf);
        n_bad++;
      end
`endif
    end
  endtask

  task automatic test_back_to_back();
    // First edge after reset release registers immediately.
    rst = 1'b0; a = 64'd10; b = 64'd35; cin = 1'b0;
    cycle();
    n_total++;
    if (sum !== 64'd45 || cout !== 1'b0) begin
      $display("FAIL b2b_first: got sum=%0d cout=%b want sum=45 cout=0", sum, cout);
      n_bad++;
    end
    a = 64'd23; b = 64'd132; cin = 1'b1;
    #2;
    n_total++;
    if (sum !== 64'd45) begin
      $display("FAIL b2b_latency: got sum=%0d want 45 before edge", sum);
      n_bad++;
    end
    cycle();
    n_total++;
    if (sum !== 64'd156 || cout !== 1'b0) begin
      $display("FAIL b2b_second: got sum=%0d cout=%b want sum=156 cout=0", sum, cout);
      n_bad++;
    end
  endtask

  task automatic test_vectors();
    rca_operand_t va [4];
    rca_operand_t vb [4];
    logic         vc [4];
    rca_operand_t vs [4];
    va[0] = 64'd3846;                vb[0] = 64'd9654;           vc[0] = 1'b0;
    vs[0] = 64'd13500;
    va[1] = 64'd866945;              vb[1] = 64'd3324752;        vc[1] = 1'b1;
    vs[1] = 64'd4191698;
    va[2] = 64'd6223372036854775808; vb[2] = 64'd38701384792384; vc[2] = 1'b1;
    vs[2] = 64'd6223410738239568193;
    va[3] = 64'h5555_5555_5555_5555; vb[3] = 64'h2AAA_AAAA_AAAA_AAAA; vc[3] = 1'b1;
    vs[3] = 64'h8000_0000_0000_0000;
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      a = va[i]; b = vb[i]; cin = vc[i];
      cycle();
      n_total++;
      if (sum !== vs[i] || cout !== 1'b0) begin
        $display("FAIL vector[%0d]: got sum=%0d cout=%b want sum=%0d cout=0",
                 i, sum, cout, vs[i]);
        n_bad++;
      end
    end
  endtask

  task automatic test_wrap();
    rst = 1'b0;
    a = '1; b = '0; cin = 1'b1;
    cycle();
    n_total++;
    if (sum !== 64'd0 || cout !== 1'b1) begin
      $display("FAIL wrap_ones_plus_one: got sum=%0h cout=%b want sum=0 cout=1", sum, cout);
      n_bad++;
    end
    a = '1; b = '1; cin = 1'b1;
    cycle();
    n_total++;
    if (sum !== 64'hFFFF_FFFF_FFFF_FFFF || cout !== 1'b1) begin
      $display("FAIL wrap_ones_ones: got sum=%0h cout=%b want sum=ffffffffffffffff cout=1",
               sum, cout);
      n_bad++;
    end
    a = 64'h7FFF_FFFF_FFFF_FFFF; b = 64'd1; cin = 1'b0;
    cycle();
    n_total++;
    if (sum !== 64'h8000_0000_0000_0000 || cout !== 1'b0) begin
      $display("FAIL signed_edge: got sum=%0h cout=%b want sum=8000000000000000 cout=0",
               sum, cout);
      n_bad++;
    end
`ifdef RCA_OVF_EN
    n_total++;
    if (ovf !== 1'b1) begin
      $display("FAIL signed_edge_ovf: got %b want 1", ovf);
      n_bad++;
    end
`endif
  endtask

  task automatic test_hold();
    rst = 1'b0; a = 64'd1000; b = 64'd2000; cin = 1'b0;
    cycle();
    // Wiggle operands between edges; output must stay put.
    for (int i = 0; i < 3; i++) begin
      a = {$urandom(), $urandom()};
      b = {$urandom(), $urandom()};
      cin = ~cin;
      #2;
      n_total++;
      if (sum !== 64'd3000 || cout !== 1'b0) begin
        $display("FAIL hold[%0d]: got sum=%0d cout=%b want sum=3000 cout=0", i, sum, cout);
        n_bad++;
      end
    end
  endtask

  task automatic test_reset_midstream();
    rst = 1'b0; a = '1; b = 64'd5; cin = 1'b0;
    cycle();
    a = 64'd77; b = 64'd88; cin = 1'b1; rst = 1'b1;
    cycle();
    n_total++;
    if (sum !== '0 || cout !== 1'b0) begin
      $display("FAIL reset_mid: got sum=%0d cout=%b want sum=0 cout=0", sum, cout);
      n_bad++;
    end
    rst = 1'b0;
    cycle();
    n_total++;
    if (sum !== 64'd166 || cout !== 1'b0) begin
      $display("FAIL reset_release: got sum=%0d cout=%b want sum=166 cout=0", sum, cout);
      n_bad++;
    end
  endtask

  task automatic test_random();
    logic [W:0] ref_full;
    logic       ref_ovf;
    int         bad_here;
    bad_here = 0;
    for (int i = 0; i < 10000; i++) begin
      a   = {$urandom(), $urandom()};
      b   = {$urandom(), $urandom()};
      if ($urandom_range(0, 7) == 0) a = '1;
      cin = 1'($urandom_range(0, 1));
      rst = ($urandom_range(0, 31) == 0);
      if (rst) begin
        ref_full = '0;
        ref_ovf  = 1'b0;
      end else begin
        ref_full = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
        ref_ovf  = (a[W-1] == b[W-1]) && (ref_full[W-1] != a[W-1]);
      end
      cycle();
      n_total++;
      if ({cout, sum} !== ref_full) begin
        n_bad++;
        if (bad_here < 10)
          $display("FAIL random[%0d]: got cout=%b sum=%0h want cout=%b sum=%0h",
                   i, cout, sum, ref_full[W], ref_full[W-1:0]);
        bad_here++;
      end
`ifdef RCA_OVF_EN
      n_total++;
      if (ovf !== ref_ovf) begin
        n_bad++;
        if (bad_here < 10)
          $display("FAIL random_ovf[%0d]: got %b want %b", i, ovf, ref_ovf);
        bad_here++;
      end
`else
      if (ref_ovf === 1'bx) $display("random ovf model unknown at %0d", i);
`endif
    end
  endtask

  initial begin
    n_total = 0;
    n_bad   = 0;
    rst = 1'b1; a = '0; b = '0; cin = 1'b0;
    test_reset();
    test_back_to_back();
    test_vectors();
    test_wrap();
    test_hold();
    test_reset_midstream();
    test_random();
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/rca_64bit.md
RCA_64BIT -- requirements
Module: rca_64bit

Interface
REQ-001 Parameter WIDTH, default 64, operand/sum width in bits; must be ≥ 1.
REQ-002 The block SHALL use one clock; reset is synchronous and active-high.
REQ-003 Port clk, input, 1, rising-edge clock for all state.
REQ-004 Port rst, input, 1, synchronous active-high reset.
REQ-005 Port a, input, WIDTH, unsigned addend A.
REQ-006 Port b, input, WIDTH, unsigned addend B.
REQ-007 Port cin, input, 1, carry-in into bit 0.
REQ-008 Port sum, output, WIDTH, registered low WIDTH bits of a+b+cin.
REQ-009 Port cout, output, 1, registered carry-out of bit WIDTH-1.
REQ-010 Port ovf, output, 1, registered two's-complement signed overflow; present only when RCA_OVF_EN is defined.

Function
REQ-011 The adder SHALL be a ripple-carry chain of WIDTH one-bit full adders; carry[0]=cin and carry[i+1]=carry-out of bit i.
REQ-012 Bit i SHALL compute s[i]=a[i]^b[i]^carry[i] and carry[i+1]=(a[i]&b[i])|(carry[i]&(a[i]^b[i])).
REQ-013 {cout,sum} SHALL equal a+b+cin evaluated at WIDTH+1 bits, with no truncation, saturation or sign extension.
REQ-014 Latency SHALL be exactly 1 cycle: the result of a/b/cin sampled at rising edge N is visible on sum/cout after edge N.
REQ-015 There is no handshake: the block SHALL accept new operands every cycle, with throughput 1 result per cycle.
REQ-016 Wrap-around: all-ones + 0 + 1 SHALL give sum=0 and cout=1; all-ones + all-ones + 1 SHALL give sum=all-ones and cout=1.
REQ-017 Outputs SHALL hold their value between clock edges; input changes between edges SHALL NOT affect the outputs until the next edge.
REQ-018 The combinational path SHALL contain no latches and no inferred "+" operator; the chain SHALL be explicit structural full adders.

Reset
REQ-019 While rst=1 at a rising edge, sum, cout (and ovf) SHALL be set to 0 at that edge, regardless of a/b/cin.
REQ-020 On the first edge with rst=0, the outputs SHALL register the current a+b+cin; no extra recovery cycle.
REQ-021 Asserting reset mid-stream SHALL discard the in-flight result; there is no other internal state.

Configuration
REQ-022 Macro RCA_OVF_EN: when defined, the ovf output SHALL exist and register carry[WIDTH]^carry[WIDTH-1]; it SHALL reset to 0.
REQ-023 When RCA_OVF_EN is not defined, the ovf port and its logic SHALL be absent, and sum/cout behaviour SHALL be unchanged.

Structure
REQ-024 Package rca_pkg SHALL hold the constant RCA_DEFAULT_WIDTH=64 and the typedef for the WIDTH-bit operand vector.
REQ-025 Sub-module full_adder (inputs a, b, ci; outputs s, co) SHALL be instantiated WIDTH times via generate; rca_64bit adds the output register stage.

Verification
REQ-026 rst=1 for 2 cycles, with any inputs -> sum=0, cout=0 (ovf=0).
REQ-027 a=10, b=35, cin=0, then a=23, b=132, cin=1 on consecutive cycles -> sum=45 then sum=156, cout=0, each one cycle after its inputs.
REQ-028 a=3846, b=9654, cin=0 -> sum=13500; a=866945, b=3324752, cin=1 -> sum=4191698; cout=0 for both.
REQ-029 a=6223372036854775808, b=38701384792384, cin=1 -> sum=6223410738239568193, cout=0.
REQ-030 a=0xFFFF_FFFF_FFFF_FFFF, b=0, cin=1 -> sum=0, cout=1; a=0x7FFF_FFFF_FFFF_FFFF, b=1, cin=0 -> sum=0x8000_0000_0000_0000, cout=0, ovf=1 (RCA_OVF_EN defined).
REQ-031 Apply 10,000 random a/b/cin, one per cycle, with random rst pulses -> every result matches a WIDTH+1-bit reference sum, delayed by 1 cycle, and reads 0 after each reset edge.
